// File: rtl/mem_stage_controller.sv
// Memory-stage access controller: IDLE/ACCESS/DONE handshake with the data memory.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES un-acked ACCESS cycles.
module mem_stage_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUOutM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  MemAck,
  input  logic [DATA_WIDTH-1:0] MemRData,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallPipe,
  output logic                  MemErr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q;
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  access_s;

  assign access_s = MemtoRegM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Access FSM with latched request, capture, timeout counter and sticky error
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_s) begin
            addr_q  <= ALUOutM;
            wdata_q <= WriteDataM;
            we_q    <= MemWriteM;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // An ack in the last counted cycle completes normally
          if (MemAck) begin
            req_q   <= 1'b0;
            state_q <= ST_DONE;
            if (!we_q) begin
              rdata_q <= MemRData;
            end else begin
              rdata_q <= rdata_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
            if (!we_q) begin
              rdata_q <= '0;
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MemErr = err_q;
`else
  // Access FSM with latched request and load-data capture; waits for ack indefinitely
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_s) begin
            addr_q  <= ALUOutM;
            wdata_q <= WriteDataM;
            we_q    <= MemWriteM;
            req_q   <= 1'b1;
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (MemAck) begin
            req_q   <= 1'b0;
            state_q <= ST_DONE;
            if (!we_q) begin
              rdata_q <= MemRData;
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            state_q <= ST_ACCESS;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MemErr = 1'b0;
`endif

  assign MemReq    = req_q;
  assign MemWe     = we_q;
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign ReadDataM = rdata_q;

  // Stall is gated by reset so an asserted RST releases the pipeline immediately
  assign StallPipe = RST & (((state_q == ST_IDLE) & access_s) | (state_q == ST_ACCESS));

endmodule
